// File: rtl/lin_hh_neuron_array.sv
// lin_hh_neuron_array: N_CH linearised Hodgkin-Huxley neurons sharing one fixed-point datapath.
// Latency: 4 compute cycles per channel, then the result is held in OUT; 5*N_CH cycles per step with out_ready high.
// Backpressure: OUT holds out_ch/out_v until out_ready; step_ready is low while busy. Macro SPIKE_DETECT_EN adds out_spike.
module lin_hh_neuron_array #(
  parameter int W      = 16,
  parameter int FRAC   = 8,
  parameter int N_CH   = 4,
  parameter int V_REST = -16640,
  parameter int G_NA   = 30720,
  parameter int G_K    = 9216,
  parameter int G_L    = 77,
  parameter int E_NA   = 12800,
  parameter int E_K    = -19712,
  parameter int E_L    = -13926,
  parameter int A_M    = 26,
  parameter int B_M    = 1024,
  parameter int A_H    = 18,
  parameter int B_H    = 256,
  parameter int A_N    = 3,
  parameter int B_N    = 32,
`ifdef SPIKE_DETECT_EN
  parameter int V_TH   = 0,
`endif
  parameter int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic signed [W-1:0] cfg_current,
  input  logic                step_valid,
  input  logic signed [W-1:0] step_dt,
  output logic                step_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_ch,
  output logic signed [W-1:0] out_v,
`ifdef SPIKE_DETECT_EN
  output logic                out_spike,
`endif
  output logic                busy
);

  localparam logic signed [W-1:0] L_MAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] L_MIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] L_ZERO   = '0;
  localparam logic signed [W-1:0] L_ONE    = W'(1 << FRAC);
  localparam logic signed [W-1:0] L_V_REST = W'(V_REST);
  localparam logic signed [W-1:0] L_G_NA   = W'(G_NA);
  localparam logic signed [W-1:0] L_G_K    = W'(G_K);
  localparam logic signed [W-1:0] L_G_L    = W'(G_L);
  localparam logic signed [W-1:0] L_E_NA   = W'(E_NA);
  localparam logic signed [W-1:0] L_E_K    = W'(E_K);
  localparam logic signed [W-1:0] L_E_L    = W'(E_L);
  localparam logic signed [W-1:0] L_A_M    = W'(A_M);
  localparam logic signed [W-1:0] L_B_M    = W'(B_M);
  localparam logic signed [W-1:0] L_A_H    = W'(A_H);
  localparam logic signed [W-1:0] L_B_H    = W'(B_H);
  localparam logic signed [W-1:0] L_A_N    = W'(A_N);
  localparam logic signed [W-1:0] L_B_N    = W'(B_N);
  localparam logic [CW-1:0]       L_LAST   = CW'(N_CH - 1);

  // Fixed-point multiply: full-width product, floor shift by FRAC, saturate to W bits.
  function automatic logic signed [W-1:0] f_mul(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    logic signed [2*W-1:0] ae;
    logic signed [2*W-1:0] be;
    logic signed [2*W-1:0] p;
    ae = {{W{a[W-1]}}, a};
    be = {{W{b[W-1]}}, b};
    p  = ae * be;
    p  = p >>> FRAC;
    if (p[2*W-1:W-1] == {(W+1){1'b0}} || p[2*W-1:W-1] == {(W+1){1'b1}})
      return p[W-1:0];
    return p[2*W-1] ? L_MIN : L_MAX;
  endfunction

  function automatic logic signed [W-1:0] f_add(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) return s[W] ? L_MIN : L_MAX;
    return s[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] f_sub(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} - {b[W-1], b};
    if (s[W] != s[W-1]) return s[W] ? L_MIN : L_MAX;
    return s[W-1:0];
  endfunction

  // Gate variable update, clamped to the physical range [0, ONE].
  function automatic logic signed [W-1:0] f_gate(input logic signed [W-1:0] g,
                                                 input logic signed [W-1:0] a_rate,
                                                 input logic signed [W-1:0] b_rate,
                                                 input logic signed [W-1:0] dt);
    logic signed [W-1:0] drive;
    logic signed [W-1:0] s;
    drive = f_sub(f_mul(a_rate, f_sub(L_ONE, g)), f_mul(b_rate, g));
    s     = f_add(g, f_mul(dt, drive));
    if (s < L_ZERO) return L_ZERO;
    if (s > L_ONE) return L_ONE;
    return s;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_COMP, S_OUT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_phase;
  logic [CW-1:0]       r_ch;
  logic signed [W-1:0] r_dt;
  logic                w_accept;
  logic                w_commit;
  logic                w_hshk;

  logic signed [W-1:0] r_v [N_CH];
  logic signed [W-1:0] r_m [N_CH];
  logic signed [W-1:0] r_h [N_CH];
  logic signed [W-1:0] r_n [N_CH];
  logic signed [W-1:0] r_i [N_CH];

  // Pipeline registers of the shared datapath, one group per compute phase.
  logic signed [W-1:0] r_i_s, r_m_nx, r_h_nx, r_n_nx, r_mh;
  logic signed [W-1:0] r_vd_na, r_vd_k, r_vd_l;
  logic signed [W-1:0] r_t_na, r_t_k, r_t_l, r_dv;
  logic signed [W-1:0] r_out_v;

  logic signed [W-1:0] w_v, w_m, w_h, w_n, w_i_now, w_v_new;
  logic                w_cfg_ok;

  assign w_v      = r_v[r_ch];
  assign w_m      = r_m[r_ch];
  assign w_h      = r_h[r_ch];
  assign w_n      = r_n[r_ch];
  assign w_cfg_ok = cfg_we && (32'(cfg_ch) < N_CH);
  // A write landing in the channel's sampling cycle is forwarded into this step.
  assign w_i_now  = (w_cfg_ok && cfg_ch == r_ch) ? cfg_current : r_i[r_ch];
  assign w_v_new  = f_add(w_v, f_mul(r_dt, r_dv));
  assign out_ch   = r_ch;
  assign out_v    = r_out_v;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    step_ready  = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_hshk      = 1'b0;
    case (r_state)
      S_IDLE: begin
        step_ready = 1'b1;
        busy       = 1'b0;
        if (step_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_COMP;
        end
      end
      S_COMP: begin
        if (r_phase == 2'd3) begin
          w_commit    = 1'b1;
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_hshk      = 1'b1;
          w_state_nxt = (r_ch == L_LAST) ? S_IDLE : S_COMP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Step bookkeeping: latched dt, channel pointer and compute phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= 2'd0;
      r_ch    <= '0;
      r_dt    <= '0;
    end else begin
      if (w_accept) begin
        r_dt    <= step_dt;
        r_ch    <= '0;
        r_phase <= 2'd0;
      end
      if (r_state == S_COMP) r_phase <= r_phase + 2'd1;
      if (w_hshk && r_ch != L_LAST) r_ch <= r_ch + CW'(1);
    end
  end

  // Shared datapath: phase 0 samples I and gates, 1 forms the currents, 2 sums dV.
  always_ff @(posedge clk) begin
    if (r_state == S_COMP) begin
      case (r_phase)
        2'd0: begin
          r_i_s   <= w_i_now;
          r_m_nx  <= f_gate(w_m, L_A_M, L_B_M, r_dt);
          r_h_nx  <= f_gate(w_h, L_A_H, L_B_H, r_dt);
          r_n_nx  <= f_gate(w_n, L_A_N, L_B_N, r_dt);
          r_mh    <= f_mul(w_m, w_h);
          r_vd_na <= f_sub(w_v, L_E_NA);
          r_vd_k  <= f_sub(w_v, L_E_K);
          r_vd_l  <= f_sub(w_v, L_E_L);
        end
        2'd1: begin
          r_t_na <= f_mul(L_G_NA, f_mul(r_mh, r_vd_na));
          r_t_k  <= f_mul(L_G_K, f_mul(w_n, r_vd_k));
          r_t_l  <= f_mul(L_G_L, r_vd_l);
        end
        2'd2: r_dv <= f_sub(f_sub(f_sub(r_i_s, r_t_na), r_t_k), r_t_l);
        default: ;
      endcase
    end
  end

  // Per-channel state: host current writes and the end-of-compute commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) begin
        r_v[k] <= L_V_REST;
        r_m[k] <= L_ZERO;
        r_h[k] <= L_ONE;
        r_n[k] <= L_ZERO;
        r_i[k] <= L_ZERO;
      end
      r_out_v <= L_ZERO;
    end else begin
      if (w_cfg_ok) r_i[cfg_ch] <= cfg_current;
      if (w_commit) begin
        r_v[r_ch] <= w_v_new;
        r_m[r_ch] <= r_m_nx;
        r_h[r_ch] <= r_h_nx;
        r_n[r_ch] <= r_n_nx;
        r_out_v   <= w_v_new;
      end
    end
  end

`ifdef SPIKE_DETECT_EN
  localparam logic signed [W-1:0] L_V_TH = W'(V_TH);
  logic r_spike;
  assign out_spike = r_spike;

  // Upward threshold crossing flag, captured alongside the new V.
  always_ff @(posedge clk) begin
    if (reset)         r_spike <= 1'b0;
    else if (w_commit) r_spike <= (w_v < L_V_TH) && (w_v_new >= L_V_TH);
  end
`endif

endmodule

// File: doc/lin_hh_neuron_array.md
Name: lin_hh_neuron_array

Overview:
- Time-multiplexed array of N_CH linearised Hodgkin-Huxley neurons in signed fixed point.
- Uses one shared datapath, with per-channel state for V, m, h, n and a per-channel input current register.
- A step request carries dt. The block then updates every channel in order 0..N_CH-1 and streams each new V out over a valid/ready interface.
- Sits between the host/config interface and downstream spike/raster logic.

Parameters:
- W, 16, data width; all values are signed two's complement Q(W-FRAC).FRAC.
- FRAC, 8, fractional bits.
- N_CH, 4, neuron channel count (>=1); CW = max(1, clog2(N_CH)).
- V_REST, -16640, reset membrane potential (-65.0).
- G_NA, 30720, sodium conductance (120.0).
- G_K, 9216, potassium conductance (36.0).
- G_L, 77, leak conductance (0.3).
- E_NA, 12800, sodium reversal potential (50.0).
- E_K, -19712, potassium reversal potential (-77.0).
- E_L, -13926, leak reversal potential (-54.4).
- A_M, 26, m opening rate. B_M, 1024, m closing rate.
- A_H, 18, h opening rate. B_H, 256, h closing rate.
- A_N, 3, n opening rate. B_N, 32, n closing rate.
- V_TH, 0, spike threshold (used only with SPIKE_DETECT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  write strobe for a channel current register
- cfg_ch  in  CW  channel index for the write
- cfg_current  in  W  current value written to I[cfg_ch]
- step_valid  in  1  step request
- step_dt  in  W  time step for the requested step
- step_ready  out  1  high only in IDLE
- out_valid  out  1  a channel result is presented
- out_ready  in  1  downstream accepts the result
- out_ch  out  CW  channel index of the presented result
- out_v  out  W  new membrane potential of that channel
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset is clk-synchronous, active-high, and wins over all other inputs, including mid-step.
  - All channels: V=V_REST, m=0, h=1<<FRAC, n=0, I=0.
  - FSM goes to IDLE. out_valid=0, out_ch=0, out_v=0, busy=0.
  - Any step in progress is abandoned.
- Arithmetic primitives:
  - mul(a,b) = (a*b) at full 2W width, arithmetic shift right by FRAC (floor), then saturate to W bits.
  - add/sub are W-bit saturating.
- Gating update, per g in {m,h,n} with rates (A,B): g' = clamp(g + mul(dt, mul(A, ONE-g) - mul(B, g)), 0, ONE), where ONE = 1<<FRAC.
- Membrane update: V' = V + mul(dt, dV), with dV evaluated strictly left to right with saturation at each stage:
  - dV = I - mul(G_NA, mul(mul(m,h), V-E_NA)) - mul(G_K, mul(n, V-E_K)) - mul(G_L, V-E_L).
  - All differences (ONE-g, V-E_x) are saturating subtracts.
- Every update of a channel uses that channel's pre-step V, m, h, n. All four registers commit together in the last compute cycle.
- dt is latched at step acceptance. I[ch] is sampled when channel ch enters compute.
- FSM states: IDLE, COMP, OUT.
  - IDLE: step_ready=1. step_valid=1 latches dt, sets ch=0 and moves to COMP.
  - COMP: exactly 4 cycles per channel (C0..C3); commits on C3, then moves to OUT.
  - OUT: out_valid=1, out_ch=ch, out_v=new V, all held stable until out_ready=1.
    - On the handshake cycle with ch < N_CH-1: ch++ and return to COMP.
    - On the handshake cycle with ch = N_CH-1: return to IDLE.
- Timing with out_ready tied high:
  - First out_valid appears 5 cycles after step acceptance.
  - Results are spaced 5 cycles apart.
  - Step-to-IDLE takes 5*N_CH cycles.
- step_valid is ignored while busy; there is no queueing.
- cfg_we is accepted in every state except reset.
  - A write to a channel that has already been sampled takes effect on the next step.
  - A write in the same cycle that channel enters compute is seen by that step.
  - A cfg_ch value >= N_CH is ignored.

Optional Feature:
- Macro SPIKE_DETECT_EN.
- When defined: adds output port out_spike (1 bit), valid with out_valid. out_spike=1 iff old V < V_TH and new V >= V_TH (upward crossing only). It resets to 0.
- When undefined: the port, comparator and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then step dt=0, I=0, out_ready=1: results for ch0..3 in order, each out_v=-16640. First result 5 cycles after acceptance; IDLE again after 20 cycles.
- Reset, I[0]=0, step dt=256: out_v(ch0)=-15823 (leak term only; floor of mul(77,-2714) = -817). A second step dt=0 returns ch0 out_v=-15823 unchanged.
- Reset, I[1]=32767, step dt=256: dV saturates to 32767 and out_v(ch1)=16127. With SPIKE_DETECT_EN, out_spike=1 for ch1 and 0 for the other channels.
- Backpressure: hold out_ready=0 for 10 cycles during ch2's result. out_valid, out_ch=2 and out_v stay stable, busy=1 and step_ready=0; a step_valid pulse in this window is ignored (only one step of 4 results).
- Assert reset while in COMP for ch1 → next cycle out_valid=0 and busy=0. A new step dt=0 then returns -16640 for every channel.
- cfg_we to ch3 with 1000 while ch0 is in OUT → ch3 uses the new I in this step. A write to ch0 at the same time is seen only on the next step. A write with cfg_ch>=N_CH has no effect.
